filter_reset_seq: RTL
=====================

// Module: filter_reset_seq
// PURPOSE
//  Reset sequencer directly downstream of the reset synchronizer. Takes the
//  synchronized reset and releases the filter core in a fixed order:
//  hold the core in reset, zero every delay-line/coefficient RAM entry, then
//  release the core and flag ready. Also provides a handshaked soft reset that
//  reruns the hold+clear sequence without touching the chip reset.
// PARAMETERS
//  HOLD_CYCLES  4   cycles core_srst is held after reset release, before clearing (>=1)
//  CLR_DEPTH    16  number of RAM entries to zero, addresses 0..CLR_DEPTH-1 (>=1)
//  ADDR_W       $clog2(CLR_DEPTH) (min 1)  width of clr_addr
// PORTS
//  clk            in   1       system clock, all logic on rising edge
//  srst           in   1       synchronous active-high reset (inverted synchronizer output)
//  soft_rst_req   in   1       level request to rerun the sequence, sampled only in READY
//  soft_rst_ack   out  1       one-cycle pulse, request accepted
//  core_srst      out  1       synchronous active-high reset to filter core
//  clr_we         out  1       RAM write enable, write data is implicitly zero
//  clr_addr       out  ADDR_W  RAM write address
//  ready          out  1       core released and RAM cleared
//  state_o        out  2       RESET=0, HOLD=1, CLEAR=2, READY=3
// BEHAVIOUR
//  - All outputs registered. srst=1 at an edge forces, after that edge:
//    state RESET, core_srst=1, clr_we=0, clr_addr=0, ready=0, soft_rst_ack=0,
//    all counters 0. srst dominates every other input in every state.
//  - RESET -> HOLD: first edge with srst=0 (call it edge k).
//  - HOLD: core_srst=1, clr_we=0. Lasts exactly HOLD_CYCLES cycles; -> CLEAR
//    at edge k+HOLD_CYCLES.
//  - CLEAR: core_srst=1, clr_we=1, clr_addr=0,1,..,CLR_DEPTH-1, one per cycle,
//    no gaps, no wrap. Lasts exactly CLR_DEPTH cycles; -> READY at edge
//    k+HOLD_CYCLES+CLR_DEPTH.
//  - READY: core_srst=0, ready=1, clr_we=0, clr_addr=0. core_srst falls and
//    ready rises at the same edge. Defaults: 20 edges after edge k.
//  - Outside CLEAR, clr_we=0 and clr_addr=0.
//  - Soft reset: soft_rst_req=1 sampled at edge m while in READY -> after edge
//    m: state HOLD, soft_rst_ack=1, ready=0, core_srst=1; ack drops at edge m+1.
//    The sequence then repeats exactly as from edge k.
//  - soft_rst_req in RESET/HOLD/CLEAR: ignored, no ack, no restart of counters.
//    A request still high on entering READY is accepted at the first READY
//    edge, so ready is high for exactly one cycle.
//  - Soft reset never asserts other srst consumers; chip reset unaffected.
//  - srst during HOLD/CLEAR: abort at that edge (clr_we=0 right after); on release
//    the full sequence restarts at addr 0 with the full hold count.
//  - srst and soft_rst_req both high in READY: srst wins, ack stays 0.
//  - Counters are sized to hold HOLD_CYCLES-1 and CLR_DEPTH-1. No overflow
//    is possible for legal parameter values. Illegal parameters
//    (HOLD_CYCLES<1 or CLR_DEPTH<1) are rejected by elaboration-time $error.
// TESTING
//  T1 power-up: srst=1 for 3 cycles, then 0 -> core_srst=1 throughout;
//     clr_we=1 from edge k+4, addr 0..15 consecutive; ready=1, core_srst=0 at
//     edge k+20.
//  T2 soft reset: 1-cycle soft_rst_req in READY -> soft_rst_ack 1 cycle,
//     ready=0, addr 0..15 swept again, ready=1 20 edges later.
//  T3 ignored request: soft_rst_req pulsed at clr_addr=5 -> no ack, sweep
//     continues 6..15. Held high into READY -> ready high 1 cycle, then ack.
//  T4 abort: srst=1 when clr_addr=7 -> next edge clr_we=0, addr=0,
//     state_o=0. Release -> full 4+16 sequence from addr 0.
//  T5 priority: srst=1 and soft_rst_req=1 together in READY -> state RESET,
//     soft_rst_ack stays 0.
//  T6 minimum params HOLD_CYCLES=1, CLR_DEPTH=1 -> one clr_we pulse,
//     addr 0; ready at edge k+2.

Source files
------------

// File: rtl/filter_reset_seq.sv
// Reset sequencer for the filter core: holds the core in reset, zeroes the
// delay-line/coefficient RAM, then releases the core; soft reset reruns hold+clear.
module filter_reset_seq #(
    parameter int HOLD_CYCLES = 4,
    parameter int CLR_DEPTH   = 16,
    parameter int ADDR_W      = (CLR_DEPTH > 1) ? $clog2(CLR_DEPTH) : 1
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              soft_rst_req,
    output logic              soft_rst_ack,
    output logic              core_srst,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              ready,
    output logic [1:0]        state_o
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(CLR_DEPTH - 1);

    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("filter_reset_seq: HOLD_CYCLES must be >= 1");
    end
    if (CLR_DEPTH < 1) begin : g_bad_depth
        $error("filter_reset_seq: CLR_DEPTH must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_HOLD  = 2'd1,
        ST_CLEAR = 2'd2,
        ST_READY = 2'd3
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_n;
    logic [ADDR_W-1:0] addr_n;
    logic              ack_n;

    // clr_addr doubles as the sweep counter; it returns to 0 whenever CLEAR is left.
    always_comb begin
        state_n    = state;
        hold_cnt_n = '0;
        addr_n     = '0;
        ack_n      = 1'b0;
        case (state)
            ST_RESET: state_n = ST_HOLD;
            ST_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_n = ST_CLEAR;
                end else begin
                    hold_cnt_n = hold_cnt + 1'b1;
                end
            end
            ST_CLEAR: begin
                if (clr_addr == ADDR_LAST) begin
                    state_n = ST_READY;
                end else begin
                    addr_n = clr_addr + 1'b1;
                end
            end
            ST_READY: begin
                if (soft_rst_req) begin
                    state_n = ST_HOLD;
                    ack_n   = 1'b1;
                end
            end
            default: state_n = ST_RESET;
        endcase
    end

    // Outputs are decoded from the next state so they are registered with it.
    always_ff @(posedge clk) begin
        if (srst) begin
            state        <= ST_RESET;
            hold_cnt     <= '0;
            clr_addr     <= '0;
            clr_we       <= 1'b0;
            core_srst    <= 1'b1;
            ready        <= 1'b0;
            soft_rst_ack <= 1'b0;
        end else begin
            state        <= state_n;
            hold_cnt     <= hold_cnt_n;
            clr_addr     <= addr_n;
            clr_we       <= (state_n == ST_CLEAR);
            core_srst    <= (state_n != ST_READY);
            ready        <= (state_n == ST_READY);
            soft_rst_ack <= ack_n;
        end
    end

    assign state_o = state;

endmodule
